// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : Pipeline-side initiator for the multiply/divide unit. Latches
//               one request, drives the MDU, waits out its latency, captures
//               the result and returns it with a one-cycle done pulse while
//               stalling the pipeline via oBusy.
//               Optional feature macro: MDU_REUSE_EN (single-entry result
//               reuse of the last completed operation).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl #(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 36,
  parameter int CNT_W       = 6
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iOperation,
  input  logic [31:0] iSrc0,
  input  logic [31:0] iSrc1,
  input  logic        iFlush,
  output logic [31:0] oMduSrc0,
  output logic [31:0] oMduSrc1,
  output logic        oMduOperation,
  input  logic [31:0] iMduResult,
  input  logic        iMduReady,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oResult,
  output logic        oDivByZero
);

  // Counter reload values: the issue cycle itself counts as one latency cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              div_zero;
  logic              capture;
  logic              reuse_hit;
  logic [31:0]       reuse_value;

  // A flush in IDLE suppresses a simultaneous start.
  assign accept   = (state == S_IDLE) && iStart && !iFlush;
  assign div_zero = iOperation && (iSrc1 == 32'd0);
  // Divide results are only valid once the divider reports ready.
  assign capture  = (state == S_WAIT) && !iFlush && (cnt == '0) &&
                    (!oMduOperation || iMduReady);

`ifdef MDU_REUSE_EN
  logic        reuse_valid;
  logic        reuse_op;
  logic [31:0] reuse_src0;
  logic [31:0] reuse_src1;

  assign reuse_hit   = reuse_valid && (reuse_op == iOperation) &&
                       (reuse_src0 == iSrc0) && (reuse_src1 == iSrc1);

  // Single-entry store of the last MDU-computed result; any flush invalidates.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      reuse_valid <= 1'b0;
      reuse_op    <= 1'b0;
      reuse_src0  <= '0;
      reuse_src1  <= '0;
      reuse_value <= '0;
    end else if (iFlush) begin
      reuse_valid <= 1'b0;
    end else if (capture) begin
      reuse_valid <= 1'b1;
      reuse_op    <= oMduOperation;
      reuse_src0  <= oMduSrc0;
      reuse_src1  <= oMduSrc1;
      reuse_value <= iMduResult;
    end
  end
`else
  assign reuse_hit   = 1'b0;
  assign reuse_value = '0;
`endif

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; requests that need no MDU go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (div_zero || reuse_hit) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = iFlush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (iFlush)       state_nxt = S_IDLE;
        else if (capture) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, latency counter and result capture.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oMduSrc0      <= '0;
      oMduSrc1      <= '0;
      oMduOperation <= 1'b0;
      cnt           <= '0;
      oResult       <= '0;
      oDivByZero    <= 1'b0;
    end else begin
      // The MDU inputs only change for requests that actually use the MDU.
      if (accept && !div_zero && !reuse_hit) begin
        oMduSrc0      <= iSrc0;
        oMduSrc1      <= iSrc1;
        oMduOperation <= iOperation;
      end
      if (state == S_ISSUE)
        cnt <= oMduOperation ? DIV_LOAD : MUL_LOAD;
      else if ((state == S_WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;
      if (accept) begin
        oDivByZero <= div_zero;
        if (div_zero)       oResult <= 32'hFFFF_FFFF;
        else if (reuse_hit) oResult <= reuse_value;
      end
      if (capture)
        oResult <= iMduResult;
    end
  end

  assign oBusy = (state != S_IDLE);
  assign oDone = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue_ctrl
// Description : Self-checking bench for mdu_issue_ctrl: table-driven request
//               vectors plus hand-written flush / reset / reuse sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;

  localparam int DIV_LAT = 36;

  logic        iClk = 1'b0;
  logic        iRst, iStart, iOperation, iFlush, iMduReady;
  logic [31:0] iSrc0, iSrc1, iMduResult;
  logic [31:0] oMduSrc0, oMduSrc1, oResult;
  logic        oMduOperation, oBusy, oDone, oDivByZero;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    int          extra;   // extra cycles iMduReady stays low at count 0
    logic [31:0] res;
    logic        dbz;
    int          lat;     // edges after the sample edge at which oDone is seen
  } vec_t;

  vec_t vecs[7];

  mdu_issue_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOperation(iOperation),
    .iSrc0(iSrc0), .iSrc1(iSrc1), .iFlush(iFlush),
    .oMduSrc0(oMduSrc0), .oMduSrc1(oMduSrc1), .oMduOperation(oMduOperation),
    .iMduResult(iMduResult), .iMduReady(iMduReady),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oDivByZero(oDivByZero)
  );

  always #5 iClk = ~iClk;

  // Reference MDU: upper product word or unsigned quotient of the driven operands.
  always_comb begin
    prod = {32'd0, oMduSrc0} * {32'd0, oMduSrc1};
    if (oMduOperation) iMduResult = (oMduSrc1 == 32'd0) ? 32'd0 : oMduSrc0 / oMduSrc1;
    else               iMduResult = prod[63:32];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and observe it to completion.
  task automatic run_vec(input vec_t v, input string tag);
    int   lat = 0;
    int   busy_n = 0;
    logic stab_bad = 1'b0;
    logic [31:0] res = '0;
    logic dbz = 1'b0;
    @(negedge iClk);
    iStart = 1'b1; iOperation = v.op; iSrc0 = v.a; iSrc1 = v.b;
    iMduReady = (v.extra == 0);
    @(posedge iClk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge iClk);
      iStart = 1'b0;
      if (oBusy) busy_n++;
      if (oBusy && !oDone &&
          (oMduSrc0 !== v.a || oMduSrc1 !== v.b || oMduOperation !== v.op))
        stab_bad = 1'b1;
      if (oDone) begin
        lat = k; res = oResult; dbz = oDivByZero;
        break;
      end
      iMduReady = (v.extra == 0) || (k >= DIV_LAT + 1 + v.extra);
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("FAIL %s timeout: no oDone within 200 cycles", tag);
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " result"}, res, v.res);
    check({tag, " divbyzero"}, {31'd0, dbz}, {31'd0, v.dbz});
    check({tag, " busy cycles"}, 32'(busy_n), 32'(v.lat));
    check({tag, " mdu operands stable"}, {31'd0, stab_bad}, 32'd0);
    @(negedge iClk);
    check({tag, " busy low after done"}, {31'd0, oBusy}, 32'd0);
    iMduReady = 1'b1;
    last_result = v.res;
  endtask

  initial begin
    vec_t rv;
    int   done_n;
    vecs[0] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0001, 1'b0, 3};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 1'b0, 3};
    vecs[2] = '{1'b1, 32'd100,       32'd7,         0, 32'd14,        1'b0, 38};
    vecs[3] = '{1'b1, 32'd1000,      32'd7,         5, 32'd142,       1'b0, 43};
    vecs[4] = '{1'b1, 32'd5,         32'd0,         0, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[5] = '{1'b0, 32'd3,         32'd5,         0, 32'd0,         1'b0, 3};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         0, 32'hFFFF_FFFF, 1'b0, 38};

    iRst = 1'b1; iStart = 1'b0; iOperation = 1'b0; iFlush = 1'b0;
    iMduReady = 1'b1; iSrc0 = '0; iSrc1 = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("reset busy", {31'd0, oBusy}, 32'd0);
    check("reset done", {31'd0, oDone}, 32'd0);
    check("reset result", oResult, 32'd0);
    check("reset divbyzero", {31'd0, oDivByZero}, 32'd0);
    check("reset mdu src0", oMduSrc0, 32'd0);
    check("reset mdu src1", oMduSrc1, 32'd0);
    check("reset mdu op", {31'd0, oMduOperation}, 32'd0);
    iRst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush in WAIT cycle 10; a start while busy must be dropped.
    @(negedge iClk);
    iStart = 1'b1; iOperation = 1'b1; iSrc0 = 32'd100; iSrc1 = 32'd3;
    @(posedge iClk);
    done_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge iClk);
      if (oDone) done_n++;
      iStart = 1'b0; iFlush = 1'b0;
      if (k == 5) begin iStart = 1'b1; iOperation = 1'b0; iSrc0 = 32'd2; iSrc1 = 32'd2; end
      if (k == 11) iFlush = 1'b1;
      if (k == 12) check("flush busy low next cycle", {31'd0, oBusy}, 32'd0);
    end
    check("flush no done", 32'(done_n), 32'd0);
    check("flush result held", oResult, last_result);

    // Flush together with start in IDLE: no request taken.
    @(negedge iClk);
    iStart = 1'b1; iFlush = 1'b1; iOperation = 1'b0; iSrc0 = 32'd9; iSrc1 = 32'd9;
    @(negedge iClk);
    check("flush+start idle busy", {31'd0, oBusy}, 32'd0);
    iStart = 1'b0; iFlush = 1'b0;

    // Repeat of an identical request: reused when the feature is built in.
    run_vec(vecs[0], "repeat first");
    rv = vecs[0];
`ifdef MDU_REUSE_EN
    rv.lat = 1;
`endif
    run_vec(rv, "repeat second");
    @(negedge iClk);
    iFlush = 1'b1;
    @(negedge iClk);
    iFlush = 1'b0;
    run_vec(vecs[0], "repeat after flush");

    // Reset in the middle of a divide; the late result must never appear.
    @(negedge iClk);
    iStart = 1'b1; iOperation = 1'b1; iSrc0 = 32'd77; iSrc1 = 32'd7;
    @(posedge iClk);
    done_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge iClk);
      if (oDone) done_n++;
      iStart = 1'b0; iRst = (k == 5);
      if (k == 6) begin
        check("midop reset busy", {31'd0, oBusy}, 32'd0);
        check("midop reset result", oResult, 32'd0);
        check("midop reset mdu src0", oMduSrc0, 32'd0);
      end
    end
    check("midop reset no done", 32'(done_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
